videoram_mp_port: RTL and testbench
===================================

Name: videoram_mp_port

Overview:
- Parametrised multi-channel front end for the video RAM slave port of the barcode scanner SoC.
- Arbitrates N independent requesters onto one videoram port: address, chipselect, clken, write, writedata, byteenable, readdata. Typical requesters are the NIOS bridge, the barcode overlay renderer and the debug dumper.
- Adds over the single-master port: configurable address/data width, channel count, read latency, a round-robin or fixed-priority mode, and per-channel read-response routing.

Parameters:
- NUM_CH, 2, number of requesting channels (1..8)
- ADDR_W, 12, videoram word address width
- DATA_W, 32, data width; must be a multiple of 8
- BE_W, DATA_W/8, byteenable width (derived; do not override)
- RD_LAT, 1, RAM read latency in cycles from the chipselect cycle to valid videoram_readdata (1..4)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- ch_valid  in  NUM_CH  request valid per channel
- ch_ready  out  NUM_CH  request accepted this cycle (one-hot or zero)
- ch_write  in  NUM_CH  1 = write, 0 = read
- ch_address  in  NUM_CH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W]
- ch_writedata  in  NUM_CH*DATA_W  write data, same packing
- ch_byteenable  in  NUM_CH*BE_W  write byte lanes, same packing
- ch_readdata  out  DATA_W  shared read-return data
- ch_readdatavalid  out  NUM_CH  one-hot strobe marking which channel owns ch_readdata
- videoram_address  out  ADDR_W  RAM address
- videoram_chipselect  out  1  RAM access strobe
- videoram_clken  out  1  RAM clock enable
- videoram_write  out  1  RAM write strobe
- videoram_writedata  out  DATA_W  RAM write data
- videoram_byteenable  out  BE_W  RAM byte lanes
- videoram_readdata  in  DATA_W  RAM read data

Behaviour:
- Clocking and reset: one clock, clk_clk. reset_reset is asynchronous and active-high.
- Reset values: every registered output is 0, including videoram_clken. The read-tracking pipe is cleared. The round-robin pointer is set so channel 0 has first priority.
- Handshake:
  - A transfer occurs on any cycle where ch_valid[i] and ch_ready[i] are both high.
  - ch_ready is combinational from ch_valid and the arbiter state. At most one bit is high.
  - Masters must not make ch_valid depend on ch_ready.
  - A master holding ch_valid keeps its request fields stable until accepted.
- Arbitration:
  - Round-robin: search starts at the last granted channel +1 and wraps at NUM_CH-1 -> 0. The pointer updates only on a grant.
  - Fixed priority: the lowest-index valid channel wins.
  - No valid requests: ch_ready = 0 and the pointer holds.
  - NUM_CH=1: ch_ready = ch_valid.
- Command stage, registered with 1 cycle latency: a handshake at cycle T drives the videoram_* outputs at T+1.
  - chipselect = 1; address from the granted channel.
  - On a write: write = 1, writedata and byteenable from the channel.
  - On a read: write = 0, byteenable = all ones.
  - Idle cycle: chipselect = 0 and write = 0; address, writedata and byteenable hold their last values.
- videoram_clken: 1 on every cycle after reset deasserts.
- Read tracking:
  - The pipe is RD_LAT+1 deep. Each entry holds a valid bit and the channel id (clog2 width, minimum 1).
  - Read accepted at T: RAM data is sampled at T+1+RD_LAT and registered to ch_readdata. ch_readdatavalid[id] pulses for exactly one cycle at T+2+RD_LAT. Total latency is 3 when RD_LAT=1.
  - Reads return in acceptance order. Full throughput: one accepted read per cycle sustained, with no back-pressure on returns.
- Writes produce no response. A write followed by a read to the same address on the next cycle returns the new data; the RAM is read-after-write ordered by port serialisation.
- ch_readdata holds its last value when no strobe is asserted.
- Reset mid-operation: in-flight reads are dropped and no ch_readdatavalid is ever asserted for them. A command registered on the reset edge is lost.
- Elaboration checks must fail on DATA_W%8 != 0, NUM_CH outside 1..8, or RD_LAT outside 1..4.

Decomposition:
- Package videoram_pkg holds:
  - Constants VRAM_ADDR_W=12 and VRAM_DATA_W=32
  - Function vram_be_w(data_w)
  - Function clog2_min1(n)
  - Arbitration mode constants ARB_RR=0 and ARB_FIXED=1
- One sub-module, videoram_rr_arbiter (NUM_CH, ARB_MODE). Inputs are valid and grant-accept; outputs are the one-hot grant and the encoded id. It owns the round-robin pointer.
- The command register and read-tracking pipe stay in the top module.

Test Plan:
1. Ch0 writes addr 0x010, data 0xDEADBEEF, be 0xF -> ch_ready[0] high the same cycle; next cycle chipselect=1, write=1, address=0x010, writedata=0xDEADBEEF, byteenable=0xF; no readdatavalid ever.
2. RD_LAT=1: ch1 reads 0x010 after step 1 -> ch_readdatavalid=2'b10 exactly 3 cycles after the handshake, ch_readdata=0xDEADBEEF, single-cycle pulse.
3. ARB_MODE=0, NUM_CH=2, both channels issue reads continuously for 8 cycles -> grants alternate 0,1,0,1,...; readdatavalid alternates 01,10,... with returned data matching the issued addresses in order.
4. ARB_MODE=1, both channels valid -> ch_ready=2'b01 every cycle; ch1 is accepted on the first cycle ch0 drops valid.
5. Write be=4'b0100, data 0x00AB0000 to an address holding 0x11223344, then read it back -> returns 0x11AB3344.
6. Two reads in flight, assert reset_reset for 2 cycles -> all outputs 0 during reset, no readdatavalid afterwards; with both channels valid after release, the first grant goes to ch0.

Source files
------------

// File: rtl/videoram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : videoram_pkg
// Brief    : Shared constants and sizing helpers for the video RAM front end.
// Revision : 1.0 - initial release
// ============================================================================
package videoram_pkg;

    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 32;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic int vram_be_w(input int data_w);
        return data_w / 8;
    endfunction

    // Channel ids keep at least one bit so single-channel builds stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/videoram_mp_port_if.sv
`default_nettype none
// ============================================================================
// Module   : videoram_mp_port_if
// Brief    : Requester channels plus the videoram slave-port wires.
// Revision : 1.0 - initial release
// ============================================================================
interface videoram_mp_port_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = videoram_pkg::VRAM_ADDR_W,
    parameter int DATA_W = videoram_pkg::VRAM_DATA_W,
    parameter int BE_W   = DATA_W / 8
);
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH*DATA_W-1:0] ch_writedata;
    logic [NUM_CH*BE_W-1:0]   ch_byteenable;
    logic [DATA_W-1:0]        ch_readdata;
    logic [NUM_CH-1:0]        ch_readdatavalid;

    logic [ADDR_W-1:0]        videoram_address;
    logic                     videoram_chipselect;
    logic                     videoram_clken;
    logic                     videoram_write;
    logic [DATA_W-1:0]        videoram_writedata;
    logic [BE_W-1:0]          videoram_byteenable;
    logic [DATA_W-1:0]        videoram_readdata;

    modport slave (
        input  ch_valid, ch_write, ch_address, ch_writedata, ch_byteenable,
        input  videoram_readdata,
        output ch_ready, ch_readdata, ch_readdatavalid,
        output videoram_address, videoram_chipselect, videoram_clken,
        output videoram_write, videoram_writedata, videoram_byteenable
    );

    modport master (
        output ch_valid, ch_write, ch_address, ch_writedata, ch_byteenable,
        output videoram_readdata,
        input  ch_ready, ch_readdata, ch_readdatavalid,
        input  videoram_address, videoram_chipselect, videoram_clken,
        input  videoram_write, videoram_writedata, videoram_byteenable
    );
endinterface
`default_nettype wire

// File: rtl/videoram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : videoram_rr_arbiter
// Brief    : Round-robin / fixed-priority grant with encoded winner id.
// Revision : 1.0 - initial release
// ============================================================================
module videoram_rr_arbiter
    import videoram_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = ARB_RR,
    parameter int ID_W     = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_valid,
    input  logic              i_accept,
    output logic [NUM_CH-1:0] o_grant,
    output logic [ID_W-1:0]   o_id
);

    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] last_d;
    logic            w_found;

    // k-th candidate of the search; round-robin starts one past the last winner.
    function automatic logic [ID_W-1:0] search_idx(input logic [ID_W-1:0] last, input int k);
        int s;
        if (ARB_MODE == ARB_FIXED) s = k - 1;
        else                       s = (int'(last) + k) % NUM_CH;
        return ID_W'(s);
    endfunction

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_found && i_valid[search_idx(last_q, k)]) begin
                o_grant[search_idx(last_q, k)] = 1'b1;
                o_id                           = search_idx(last_q, k);
                w_found                        = 1'b1;
            end
        end
        last_d = (i_accept && w_found) ? o_id : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= ID_W'(NUM_CH - 1);
        else     last_q <= last_d;
    end

endmodule
`default_nettype wire

// File: rtl/videoram_mp_port.sv
`default_nettype none
// ============================================================================
// Module   : videoram_mp_port
// Brief    : N-channel arbiter, command register and read-return router
//            in front of a single videoram slave port.
// Revision : 1.0 - initial release
// ============================================================================
module videoram_mp_port
    import videoram_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int BE_W     = vram_be_w(DATA_W),
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    videoram_mp_port_if.slave bus
);

    localparam int ID_W = clog2_min1(NUM_CH);

    if (DATA_W % 8 != 0) begin : g_chk_data_w
        $error("videoram_mp_port: DATA_W must be a multiple of 8");
    end
    if (BE_W != DATA_W / 8) begin : g_chk_be_w
        $error("videoram_mp_port: BE_W must equal DATA_W/8");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_num_ch
        $error("videoram_mp_port: NUM_CH must be in 1..8");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_rd_lat
        $error("videoram_mp_port: RD_LAT must be in 1..4");
    end

    logic [NUM_CH-1:0] w_grant;
    logic [ID_W-1:0]   w_gid;
    logic              w_accept;

    logic                       cs_q, cs_d, wr_q, wr_d, clken_q, clken_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d, rdata_q, rdata_d;
    logic [BE_W-1:0]            be_q, be_d;
    logic [NUM_CH-1:0]          rdv_q, rdv_d;
    logic [RD_LAT:0]            pipe_vld_q, pipe_vld_d;
    logic [RD_LAT:0][ID_W-1:0]  pipe_id_q, pipe_id_d;

    // Nothing is accepted while reset is held, so ready is forced low too.
    assign w_accept     = ~reset_reset & (|bus.ch_valid);
    assign bus.ch_ready = reset_reset ? '0 : w_grant;

    videoram_rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE),
        .ID_W     (ID_W)
    ) u_arb (
        .clk      (clk_clk),
        .rst      (reset_reset),
        .i_valid  (bus.ch_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant),
        .o_id     (w_gid)
    );

    always_comb begin
        cs_d       = w_accept;
        wr_d       = 1'b0;
        clken_d    = 1'b1;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        pipe_vld_d = '0;
        pipe_id_d  = '0;
        rdv_d      = '0;
        rdata_d    = rdata_q;

        if (w_accept) begin
            addr_d = bus.ch_address[int'(w_gid)*ADDR_W +: ADDR_W];
            wr_d   = bus.ch_write[w_gid];
            if (bus.ch_write[w_gid]) begin
                wdata_d = bus.ch_writedata[int'(w_gid)*DATA_W +: DATA_W];
                be_d    = bus.ch_byteenable[int'(w_gid)*BE_W +: BE_W];
            end else begin
                be_d    = '1;
            end
        end

        // Stage j is live during the j-th cycle after the RAM chipselect cycle.
        pipe_vld_d[0] = w_accept & ~bus.ch_write[w_gid];
        pipe_id_d[0]  = w_gid;
        for (int j = 1; j <= RD_LAT; j++) begin
            pipe_vld_d[j] = pipe_vld_q[j-1];
            pipe_id_d[j]  = pipe_id_q[j-1];
        end

        if (pipe_vld_q[RD_LAT]) begin
            rdv_d[pipe_id_q[RD_LAT]] = 1'b1;
            rdata_d                  = bus.videoram_readdata;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            clken_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
            rdv_q      <= '0;
            rdata_q    <= '0;
        end else begin
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            clken_q    <= clken_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
            rdv_q      <= rdv_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.videoram_address    = addr_q;
    assign bus.videoram_chipselect = cs_q;
    assign bus.videoram_clken      = clken_q;
    assign bus.videoram_write      = wr_q;
    assign bus.videoram_writedata  = wdata_q;
    assign bus.videoram_byteenable = be_q;
    assign bus.ch_readdata         = rdata_q;
    assign bus.ch_readdatavalid    = rdv_q;

endmodule
`default_nettype wire

// File: tb/tb_videoram_mp_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_videoram_mp_port
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            random traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_videoram_mp_port;
    import videoram_pkg::*;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_init = 1'b1;
    always #5 clk = ~clk;

    videoram_mp_port_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus_rr ();
    videoram_mp_port_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus_fx ();

    videoram_mp_port #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
                       .RD_LAT(RD_LAT), .ARB_MODE(ARB_RR)) dut_rr (
        .clk_clk(clk), .reset_reset(rst), .bus(bus_rr));

    videoram_mp_port #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
                       .RD_LAT(RD_LAT), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk_clk(clk), .reset_reset(rst), .bus(bus_fx));

    assign bus_fx.videoram_readdata = '0;

    // Single-cycle-latency RAM behind the round-robin instance.
    logic [31:0] ram [4096];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 32'h11223344 + 32'(i);
        end else if (bus_rr.videoram_chipselect && bus_rr.videoram_clken) begin
            if (bus_rr.videoram_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus_rr.videoram_byteenable[b])
                        ram[bus_rr.videoram_address][8*b +: 8] <= bus_rr.videoram_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[bus_rr.videoram_address];
            end
        end
    end
    assign bus_rr.videoram_readdata = ram_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; int ch; logic [31:0] data; } rd_t;
    rd_t          rq[$];
    logic [31:0]  smem [4096];
    int           cyc = 0;
    int           rr_last;
    logic         exp_cs, exp_wr, exp_clken;
    logic [11:0]  exp_addr;
    logic [31:0]  exp_wd, exp_rdata;
    logic [3:0]   exp_be;

    function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] v, input int last);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (last + k) % NUM_CH;
            if (v[c] && r == '0) r[c] = 1'b1;
        end
        return r;
    endfunction

    initial begin : model
        logic [NUM_CH-1:0] g, erdv;
        logic [11:0]       a;
        logic [31:0]       d;
        logic [3:0]        be;
        int                ch;
        for (int i = 0; i < 4096; i++) smem[i] = 32'h11223344 + 32'(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_cs",    {63'd0, bus_rr.videoram_chipselect}, 64'd0);
                chk("rst_clken", {63'd0, bus_rr.videoram_clken}, 64'd0);
                chk("rst_wr",    {63'd0, bus_rr.videoram_write}, 64'd0);
                chk("rst_addr",  {52'd0, bus_rr.videoram_address}, 64'd0);
                chk("rst_wd",    {32'd0, bus_rr.videoram_writedata}, 64'd0);
                chk("rst_be",    {60'd0, bus_rr.videoram_byteenable}, 64'd0);
                chk("rst_rdata", {32'd0, bus_rr.ch_readdata}, 64'd0);
                chk("rst_rdv",   {62'd0, bus_rr.ch_readdatavalid}, 64'd0);
                chk("rst_ready", {62'd0, bus_rr.ch_ready}, 64'd0);
                rq.delete();
                rr_last = NUM_CH - 1;
                {exp_cs, exp_wr, exp_clken} = 3'b000;
                exp_addr = '0; exp_wd = '0; exp_be = '0; exp_rdata = '0;
            end else begin
                erdv = '0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    erdv[rq[0].ch] = 1'b1;
                    exp_rdata      = rq[0].data;
                    void'(rq.pop_front());
                end
                chk("rdv",   {62'd0, bus_rr.ch_readdatavalid}, {62'd0, erdv});
                chk("rdata", {32'd0, bus_rr.ch_readdata}, {32'd0, exp_rdata});
                chk("cs",    {63'd0, bus_rr.videoram_chipselect}, {63'd0, exp_cs});
                chk("wr",    {63'd0, bus_rr.videoram_write}, {63'd0, exp_wr});
                chk("clken", {63'd0, bus_rr.videoram_clken}, {63'd0, exp_clken});
                chk("addr",  {52'd0, bus_rr.videoram_address}, {52'd0, exp_addr});
                chk("wd",    {32'd0, bus_rr.videoram_writedata}, {32'd0, exp_wd});
                chk("be",    {60'd0, bus_rr.videoram_byteenable}, {60'd0, exp_be});
                g = rr_pick(bus_rr.ch_valid, rr_last);
                chk("ready", {62'd0, bus_rr.ch_ready}, {62'd0, g});

                exp_cs = |g; exp_wr = 1'b0; exp_clken = 1'b1;
                if (|g) begin
                    ch = g[1] ? 1 : 0;
                    rr_last  = ch;
                    a        = bus_rr.ch_address[ch*ADDR_W +: ADDR_W];
                    exp_addr = a;
                    if (bus_rr.ch_write[ch]) begin
                        d  = bus_rr.ch_writedata[ch*DATA_W +: DATA_W];
                        be = bus_rr.ch_byteenable[ch*BE_W +: BE_W];
                        exp_wr = 1'b1; exp_wd = d; exp_be = be;
                        for (int b = 0; b < 4; b++)
                            if (be[b]) smem[a][8*b +: 8] = d[8*b +: 8];
                    end else begin
                        exp_be = '1;
                        rq.push_back('{cyc + 2 + RD_LAT, ch, smem[a]});
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic w, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        bus_rr.ch_valid[ch]                    = v;
        bus_rr.ch_write[ch]                    = w;
        bus_rr.ch_address[ch*ADDR_W +: ADDR_W] = a;
        bus_rr.ch_writedata[ch*DATA_W +: DATA_W] = d;
        bus_rr.ch_byteenable[ch*BE_W +: BE_W]  = be;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  w;
        logic [11:0] a0, a1;
        logic [31:0] d0;
        logic [3:0]  be0;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rdv;
    } vec_t;
    vec_t tbl [9];

    initial begin : stim
        logic [1:0]  prev;
        logic [1:0]  pend;
        logic [1:0]  acc;
        int          n0, n1;

        tbl[0] = '{2'b01, 2'b01, 12'h010, 12'h000, 32'hDEADBEEF, 4'hF, 2'b01, 2'b00};
        tbl[1] = '{2'b10, 2'b00, 12'h000, 12'h010, 32'h0, 4'h0, 2'b10, 2'b00};
        tbl[2] = '{2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 4'h0, 2'b00, 2'b00};
        tbl[3] = '{2'b11, 2'b00, 12'h020, 12'h021, 32'h0, 4'h0, 2'b01, 2'b00};
        tbl[4] = '{2'b11, 2'b00, 12'h022, 12'h021, 32'h0, 4'h0, 2'b10, 2'b10};
        tbl[5] = '{2'b11, 2'b00, 12'h022, 12'h023, 32'h0, 4'h0, 2'b01, 2'b00};
        tbl[6] = '{2'b10, 2'b00, 12'h000, 12'h023, 32'h0, 4'h0, 2'b10, 2'b01};
        tbl[7] = '{2'b10, 2'b00, 12'h000, 12'h024, 32'h0, 4'h0, 2'b10, 2'b10};
        tbl[8] = '{2'b11, 2'b00, 12'h025, 12'h026, 32'h0, 4'h0, 2'b01, 2'b01};

        bus_rr.ch_valid = '0; bus_rr.ch_write = '0; bus_rr.ch_address = '0;
        bus_rr.ch_writedata = '0; bus_rr.ch_byteenable = '0;
        bus_fx.ch_valid = '0; bus_fx.ch_write = '0; bus_fx.ch_address = '0;
        bus_fx.ch_writedata = '0; bus_fx.ch_byteenable = '0;

        next();
        ram_init = 1'b0;
        next();
        rst = 1'b0;

        // Vector table: single write, read-back, round-robin sharing.
        for (int i = 0; i < 9; i++) begin
            set_ch(0, tbl[i].v[0], tbl[i].w[0], tbl[i].a0, tbl[i].d0, tbl[i].be0);
            set_ch(1, tbl[i].v[1], tbl[i].w[1], tbl[i].a1, 32'h0, 4'h0);
            @(negedge clk);
            chk("tbl_ready", {62'd0, bus_rr.ch_ready}, {62'd0, tbl[i].exp_ready});
            chk("tbl_rdv", {62'd0, bus_rr.ch_readdatavalid}, {62'd0, tbl[i].exp_rdv});
            if (i == 1) begin
                chk("wr_cmd", {bus_rr.videoram_chipselect, bus_rr.videoram_write,
                               bus_rr.videoram_address, bus_rr.videoram_byteenable,
                               bus_rr.videoram_writedata},
                              {1'b1, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF});
            end
            if (i == 4) chk("rd_data_0x010", {32'd0, bus_rr.ch_readdata}, 64'hDEADBEEF);
            next();
        end
        bus_rr.ch_valid = '0;
        repeat (4) next();

        // Byte-lane merge followed by read-after-write on the next cycle.
        set_ch(0, 1'b1, 1'b1, 12'h000, 32'h00AB0000, 4'b0100);
        next();
        set_ch(0, 1'b1, 1'b0, 12'h000, 32'h0, 4'h0);
        next();
        bus_rr.ch_valid = '0;
        next();
        next();
        @(negedge clk);
        chk("be_merge_rdv", {62'd0, bus_rr.ch_readdatavalid}, 64'd1);
        chk("be_merge_data", {32'd0, bus_rr.ch_readdata}, 64'h11AB3344);
        next();
        repeat (3) next();

        // Continuous reads from both channels must alternate grants.
        n0 = 0; n1 = 0; prev = '0;
        for (int i = 0; i < 8; i++) begin
            set_ch(0, 1'b1, 1'b0, 12'h100 + 12'(n0), 32'h0, 4'h0);
            set_ch(1, 1'b1, 1'b0, 12'h200 + 12'(n1), 32'h0, 4'h0);
            @(negedge clk);
            if (i > 0) chk("rr_alternate", {62'd0, bus_rr.ch_ready}, {62'd0, ~prev});
            prev = bus_rr.ch_ready;
            if (prev[0]) n0++;
            if (prev[1]) n1++;
            next();
        end
        bus_rr.ch_valid = '0;
        repeat (5) next();

        // Fixed priority: channel 0 always wins while it requests.
        bus_fx.ch_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fx_ready_both", {62'd0, bus_fx.ch_ready}, 64'd1);
            next();
        end
        bus_fx.ch_valid = 2'b10;
        @(negedge clk);
        chk("fx_ready_ch1", {62'd0, bus_fx.ch_ready}, 64'd2);
        next();
        bus_fx.ch_valid = 2'b00;
        next();

        // Reset with two reads in flight.
        set_ch(0, 1'b1, 1'b0, 12'h030, 32'h0, 4'h0);
        set_ch(1, 1'b0, 1'b0, 12'h031, 32'h0, 4'h0);
        next();
        set_ch(0, 1'b0, 1'b0, 12'h030, 32'h0, 4'h0);
        set_ch(1, 1'b1, 1'b0, 12'h031, 32'h0, 4'h0);
        next();
        bus_rr.ch_valid = '0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_outs", {bus_rr.videoram_chipselect, bus_rr.videoram_clken,
                             bus_rr.videoram_write, bus_rr.ch_readdatavalid, bus_rr.ch_ready},
                            64'd0);
            next();
        end
        rst = 1'b0;
        bus_rr.ch_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_grant", {62'd0, bus_rr.ch_ready}, 64'd1);
        chk("post_rst_rdv0", {62'd0, bus_rr.ch_readdatavalid}, 64'd0);
        next();
        bus_rr.ch_valid = 2'b10;
        @(negedge clk);
        chk("post_rst_rdv1", {62'd0, bus_rr.ch_readdatavalid}, 64'd0);
        next();
        bus_rr.ch_valid = '0;
        repeat (4) next();

        // Random traffic against the reference model.
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!pend[c])
                    set_ch(c, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                           12'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            end
            @(negedge clk);
            acc  = bus_rr.ch_ready;
            pend = bus_rr.ch_valid & ~acc;
            next();
        end
        bus_rr.ch_valid = '0;
        repeat (8) next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
